name_greeter: RTL and testbench
===============================

NAME_GREETER -- requirements
Module: name_greeter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum stored name characters (range 1..64).
REQ-002 SHALL have clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have rx_data  input  8  received byte from AVR serial interface.
REQ-005 SHALL have new_rx_data  input  1  one-cycle strobe: rx_data valid this cycle.
REQ-006 SHALL have tx_data  output  8  byte to transmit to AVR serial interface.
REQ-007 SHALL have new_tx_data  output  1  one-cycle strobe: send tx_data.
REQ-008 SHALL have tx_busy  input  1  transmitter busy; no new byte accepted while high.

Function
REQ-009 SHALL implement states COLLECT, SEND_PREFIX, SEND_NAME, SEND_SUFFIX.
REQ-010 In COLLECT, on new_rx_data with byte not 0x0D/0x0A, SHALL store byte at index len and increment len if len < MAX_LEN; otherwise discard the byte.
REQ-011 In COLLECT, on new_rx_data with 0x0D or 0x0A and len > 0, SHALL enter SEND_PREFIX with byte index 0 next cycle.
REQ-012 Terminator with len = 0 SHALL be ignored (no output; CR-LF pairs therefore produce one response).
REQ-013 SEND_PREFIX SHALL transmit "Hello " (0x48 0x65 0x6C 0x6C 0x6F 0x20), then SEND_NAME.
REQ-014 SEND_NAME SHALL transmit stored bytes 0..len-1 in order, then SEND_SUFFIX.
REQ-015 SEND_SUFFIX SHALL transmit "!\r\n" (0x21 0x0D 0x0A), then clear len to 0 and return to COLLECT.
REQ-016 new_tx_data SHALL assert only in a cycle where tx_busy = 0 and new_tx_data was 0 in the previous cycle (one-cycle gap for busy to rise).
REQ-017 tx_data SHALL be valid in every cycle new_tx_data = 1; value otherwise don't-care.
REQ-018 new_tx_data SHALL be a single-cycle pulse per byte; each response byte sent exactly once.
REQ-019 tx_busy held high SHALL stall indefinitely with no byte lost or repeated.
REQ-020 new_rx_data in any SEND state SHALL be ignored (bytes dropped, buffer unchanged).
REQ-021 Minimum response length SHALL be 10 bytes (1-character name), maximum MAX_LEN+9.
REQ-022 With tx_busy permanently low, consecutive new_tx_data pulses SHALL be exactly 2 cycles apart.
REQ-023 First new_tx_data of a response SHALL occur no later than 2 cycles after the terminator strobe when tx_busy = 0.
REQ-024 Index counters SHALL be sized ceil(log2(MAX_LEN+1)) bits; no wrap-around in normal operation.

Reset
REQ-025 While rst = 1: state = COLLECT, len = 0, byte index = 0, new_tx_data = 0, tx_data = 0x00.
REQ-026 Reset asserted mid-response SHALL abort it immediately; no further bytes of that response after reset release.
REQ-027 Name buffer contents need not be reset; they SHALL be unreadable until rewritten (len = 0).

Structure
REQ-028 ASCII constants (CR, LF, prefix and suffix byte tables, their lengths) SHALL reside in shared package name_greeter_pkg.
REQ-029 Name storage SHALL be a sub-module name_buffer (MAX_LEN x 8, one write port, one asynchronous read port).
REQ-030 Control SHALL be a single FSM plus byte-index counter in name_greeter.

Verification
REQ-031 Rx "Bob" 0x0D, tx_busy = 0 -> tx bytes 48 65 6C 6C 6F 20 42 6F 62 21 0D 0A, pulses 2 cycles apart.
REQ-032 Rx 20 characters 'A'..'T' then 0x0A, MAX_LEN = 16 -> "Hello ABCDEFGHIJKLMNOP!\r\n" (25 bytes).
REQ-033 Rx 0x0D 0x0A alone, and "Al" 0x0D 0x0A -> no output for first; exactly one 11-byte response for second.
REQ-034 Rx "Jo" 0x0D, tx_busy high 50 cycles after each pulse -> same 11 bytes, none duplicated, no pulse while busy high.
REQ-035 Rx "Zed" 0x0D, "XY" during response -> response names "Zed"; next "Q" 0x0D yields "Hello Q!\r\n".
REQ-036 Assert rst after third tx byte of a response -> new_tx_data 0 from reset; after release, "Ok" 0x0D yields fresh "Hello Ok!\r\n".

Source files
------------

// File: rtl/name_greeter_pkg.sv
// Shared ASCII constants, response tables and FSM state encoding for the name greeter.
package name_greeter_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam int unsigned PREFIX_LEN = 6;
    localparam int unsigned SUFFIX_LEN = 3;

    localparam logic [7:0] PREFIX [PREFIX_LEN] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20};
    localparam logic [7:0] SUFFIX [SUFFIX_LEN] = '{8'h21, 8'h0D, 8'h0A};

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SEND_PREFIX,
        ST_SEND_NAME,
        ST_SEND_SUFFIX
    } state_t;

    function automatic logic [7:0] prefix_byte(input logic [2:0] i);
        return (i < 3'(PREFIX_LEN)) ? PREFIX[i] : 8'h00;
    endfunction

    function automatic logic [7:0] suffix_byte(input logic [1:0] i);
        return (i < 2'(SUFFIX_LEN)) ? SUFFIX[i] : 8'h00;
    endfunction

endpackage

// File: rtl/name_greeter_buffer.sv
// Name storage: MAX_LEN x 8, one synchronous write port, one asynchronous read port.
module name_buffer #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    // Contents are deliberately not reset; the stored length gates every read.
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/name_greeter.sv
// Collects a name from the serial link and replies "Hello <name>!\r\n" on the terminator.
module name_greeter #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy
);
    import name_greeter_pkg::*;

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    // The index also walks the 6-byte prefix, so it never drops below 3 bits.
    localparam int unsigned IDX_W  = (LEN_W > 3) ? LEN_W : 3;
    localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [7:0]         tx_data_nxt;
    logic               new_tx_nxt;
    logic               wr_en_c;
    logic               send_ok_c;
    logic               is_term_c;
    logic [7:0]         rd_data;

    name_buffer #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (ADDR_W)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (ADDR_W'(len)),
        .wr_data (rx_data),
        .rd_addr (ADDR_W'(idx)),
        .rd_data (rd_data)
    );

    // A byte may go out only if the transmitter is idle and we left it a cycle to raise busy.
    assign send_ok_c = !tx_busy && !new_tx_data;
    assign is_term_c = (rx_data == CR) || (rx_data == LF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_COLLECT;
            len         <= '0;
            idx         <= '0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            idx         <= idx_nxt;
            tx_data     <= tx_data_nxt;
            new_tx_data <= new_tx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        idx_nxt     = idx;
        tx_data_nxt = tx_data;
        new_tx_nxt  = 1'b0;
        wr_en_c     = 1'b0;

        case (state)
            ST_COLLECT: begin
                if (new_rx_data) begin
                    if (is_term_c) begin
                        if (len != '0) begin
                            state_nxt = ST_SEND_PREFIX;
                            idx_nxt   = '0;
                        end
                    end else if (len < LEN_W'(MAX_LEN)) begin
                        wr_en_c = 1'b1;
                        len_nxt = len + LEN_W'(1);
                    end
                end
            end

            ST_SEND_PREFIX: begin
                if (send_ok_c) begin
                    tx_data_nxt = prefix_byte(3'(idx));
                    new_tx_nxt  = 1'b1;
                    if (idx == IDX_W'(PREFIX_LEN - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = ST_SEND_NAME;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            ST_SEND_NAME: begin
                if (send_ok_c) begin
                    tx_data_nxt = rd_data;
                    new_tx_nxt  = 1'b1;
                    if (idx + IDX_W'(1) == IDX_W'(len)) begin
                        idx_nxt   = '0;
                        state_nxt = ST_SEND_SUFFIX;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            ST_SEND_SUFFIX: begin
                if (send_ok_c) begin
                    tx_data_nxt = suffix_byte(2'(idx));
                    new_tx_nxt  = 1'b1;
                    if (idx == IDX_W'(SUFFIX_LEN - 1)) begin
                        idx_nxt   = '0;
                        len_nxt   = '0;
                        state_nxt = ST_COLLECT;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_COLLECT;
                idx_nxt   = '0;
                len_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_name_greeter.sv
// Directed bench for name_greeter: table of name/terminator vectors plus hand-written corner sequences.
module tb_name_greeter;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;

    name_greeter #(.MAX_LEN(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy)
    );

    typedef struct {
        string      rx;
        logic [7:0] term;
        string      exp_name;
        bit         busy;
    } vec_t;

    vec_t       vecs [5];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         term_cyc = 0;
    bit         busy_mode = 0;
    int         busy_cnt = 0;
    logic       prev_ntx = 1'b0;
    logic [7:0] got_b [$];
    int         got_t [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic chk_true(input string nm, input bit ok, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Transmit monitor and transmitter-busy model.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && new_tx_data) begin
                got_b.push_back(tx_data);
                got_t.push_back(cyc);
                chk("pulse_while_busy", int'(tx_busy), 0);
                chk("pulse_without_gap", int'(prev_ntx), 0);
                if (busy_mode) begin
                    tx_busy  = 1'b1;
                    busy_cnt = 50;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            prev_ntx = new_tx_data;
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_term(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        term_cyc    = cyc;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_rx(s[i]);
    endtask

    task automatic clear_log();
        got_b.delete();
        got_t.delete();
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        repeat (cycles) @(negedge clk);
        chk(nm, got_b.size(), 0);
    endtask

    task automatic check_resp(input string nm, input string exp_name, input bit busy);
        logic [7:0] exp_q [$];
        int         k;
        int         n;
        exp_q = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20};
        for (int i = 0; i < exp_name.len(); i++) exp_q.push_back(exp_name[i]);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        k = 0;
        while (got_b.size() < exp_q.size() && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (120) @(negedge clk);
        chk({nm, "_count"}, got_b.size(), exp_q.size());
        n = (got_b.size() < exp_q.size()) ? got_b.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", nm, i), int'(got_b[i]), int'(exp_q[i]));
        end
        if (got_t.size() > 0) begin
            chk_true({nm, "_latency"}, (got_t[0] - term_cyc) <= 2, got_t[0] - term_cyc, 2);
        end
        for (int i = 1; i < n; i++) begin
            if (busy) begin
                chk_true($sformatf("%s_stall%0d", nm, i), (got_t[i] - got_t[i-1]) >= 51,
                         got_t[i] - got_t[i-1], 51);
            end else begin
                chk($sformatf("%s_gap%0d", nm, i), got_t[i] - got_t[i-1], 2);
            end
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{rx: "Bob",                  term: 8'h0D, exp_name: "Bob",              busy: 1'b0};
        vecs[1] = '{rx: "ABCDEFGHIJKLMNOPQRST", term: 8'h0A, exp_name: "ABCDEFGHIJKLMNOP", busy: 1'b0};
        vecs[2] = '{rx: "X",                    term: 8'h0D, exp_name: "X",                busy: 1'b0};
        vecs[3] = '{rx: "Jo",                   term: 8'h0D, exp_name: "Jo",               busy: 1'b1};
        vecs[4] = '{rx: "ABCDEFGHIJKLMNOP",     term: 8'h0A, exp_name: "ABCDEFGHIJKLMNOP", busy: 1'b0};

        rst         = 1'b1;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_new_tx_data", int'(new_tx_data), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        expect_quiet("idle_quiet", 10);

        for (int v = 0; v < 5; v++) begin
            clear_log();
            busy_mode = vecs[v].busy;
            send_str(vecs[v].rx);
            send_term(vecs[v].term);
            check_resp($sformatf("vec%0d", v), vecs[v].exp_name, vecs[v].busy);
            busy_mode = 1'b0;
        end

        // Bare CR-LF produces nothing; "Al" CR-LF produces exactly one response.
        clear_log();
        send_term(8'h0D);
        send_rx(8'h0A);
        expect_quiet("crlf_empty", 30);
        clear_log();
        send_str("Al");
        send_term(8'h0D);
        send_rx(8'h0A);
        check_resp("al_crlf", "Al", 1'b0);

        // Bytes arriving mid-response are dropped.
        clear_log();
        send_str("Zed");
        send_term(8'h0D);
        send_str("XY");
        check_resp("zed", "Zed", 1'b0);
        clear_log();
        send_str("Q");
        send_term(8'h0D);
        check_resp("q_after", "Q", 1'b0);

        // Reset mid-response aborts it.
        clear_log();
        send_str("Bob");
        send_term(8'h0D);
        k = 0;
        while (got_b.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reset_reached3", got_b.size(), 3);
        rst = 1'b1;
        #1;
        chk("mid_reset_new_tx_data", int'(new_tx_data), 0);
        chk("mid_reset_tx_data", int'(tx_data), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_log();
        expect_quiet("after_reset_quiet", 40);
        clear_log();
        send_str("Ok");
        send_term(8'h0D);
        check_resp("ok_after_reset", "Ok", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1);
    end

endmodule
